// File: rtl/sound_pkg.sv
// Shared types and constants for the melody sequencer.
//   state_t      : sequencer states (IDLE, LOAD, PLAY, GAP)
//   note_t       : one note-table entry {half_period, beats}
//   note_table_t : the full 16-entry table
// The package also provides note divisors for the default clock, the REST and
// END_MARK codes, and the default melody.
package sound_pkg;

  localparam int unsigned CLK_HZ_DEF = 25_000_000;
  localparam int unsigned TABLE_LEN  = 16;
  localparam int unsigned IDX_W      = 4;
  localparam int unsigned HALF_W     = 16;
  localparam int unsigned BEATS_W    = 3;
  localparam int unsigned CNT_W      = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    GAP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [HALF_W-1:0]  half_period;
    logic [BEATS_W-1:0] beats;
  } note_t;

  typedef note_t [TABLE_LEN-1:0] note_table_t;

  localparam logic [HALF_W-1:0] REST     = 16'h0000;
  localparam logic [HALF_W-1:0] END_MARK = 16'hFFFF;

  // Tone frequencies in Hz, rounded to the nearest integer.
  localparam int unsigned F_C4 = 262;
  localparam int unsigned F_D4 = 294;
  localparam int unsigned F_E4 = 330;
  localparam int unsigned F_F4 = 349;
  localparam int unsigned F_G4 = 392;
  localparam int unsigned F_A4 = 440;
  localparam int unsigned F_B4 = 494;
  localparam int unsigned F_C5 = 523;

  // Half-period in clock cycles for a tone; a square wave toggles at this rate.
  function automatic logic [HALF_W-1:0] half_div(input int unsigned clk_hz,
                                                 input int unsigned freq_hz);
    return HALF_W'(clk_hz / freq_hz / 2);
  endfunction

  // Note length in cycles; beats = 0 plays as one beat. Fits 32 bits while
  // beat_ticks < 2^28 because beats never exceeds 7.
  function automatic logic [CNT_W-1:0] note_ticks(input logic [BEATS_W-1:0] beats,
                                                  input int unsigned beat_ticks);
    logic [BEATS_W-1:0] b;
    b = (beats == '0) ? BEATS_W'(1) : beats;
    return CNT_W'(b) * CNT_W'(beat_ticks);
  endfunction

  localparam logic [HALF_W-1:0] C4 = half_div(CLK_HZ_DEF, F_C4);
  localparam logic [HALF_W-1:0] D4 = half_div(CLK_HZ_DEF, F_D4);
  localparam logic [HALF_W-1:0] E4 = half_div(CLK_HZ_DEF, F_E4);
  localparam logic [HALF_W-1:0] F4 = half_div(CLK_HZ_DEF, F_F4);
  localparam logic [HALF_W-1:0] G4 = half_div(CLK_HZ_DEF, F_G4);
  localparam logic [HALF_W-1:0] A4 = half_div(CLK_HZ_DEF, F_A4);
  localparam logic [HALF_W-1:0] B4 = half_div(CLK_HZ_DEF, F_B4);
  localparam logic [HALF_W-1:0] C5 = half_div(CLK_HZ_DEF, F_C5);

  // Opening phrase of "Twinkle, Twinkle", terminated by END_MARK.
  function automatic note_table_t default_table(input int unsigned clk_hz);
    note_table_t t;
    for (int unsigned i = 0; i < TABLE_LEN; i++) begin
      t[IDX_W'(i)] = '{half_period: END_MARK, beats: BEATS_W'(0)};
    end
    t[0]  = '{half_div(clk_hz, F_C4), 3'd1};
    t[1]  = '{half_div(clk_hz, F_C4), 3'd1};
    t[2]  = '{half_div(clk_hz, F_G4), 3'd1};
    t[3]  = '{half_div(clk_hz, F_G4), 3'd1};
    t[4]  = '{half_div(clk_hz, F_A4), 3'd1};
    t[5]  = '{half_div(clk_hz, F_A4), 3'd1};
    t[6]  = '{half_div(clk_hz, F_G4), 3'd2};
    t[7]  = '{half_div(clk_hz, F_F4), 3'd1};
    t[8]  = '{half_div(clk_hz, F_F4), 3'd1};
    t[9]  = '{half_div(clk_hz, F_E4), 3'd1};
    t[10] = '{half_div(clk_hz, F_E4), 3'd1};
    t[11] = '{half_div(clk_hz, F_D4), 3'd1};
    t[12] = '{half_div(clk_hz, F_D4), 3'd1};
    t[13] = '{half_div(clk_hz, F_C4), 3'd2};
    return t;
  endfunction

  localparam note_table_t DEFAULT_TABLE = default_table(CLK_HZ_DEF);

endpackage

// File: rtl/tone_gen.sv
// Loadable half-period square-wave divider.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : synchronous clear of counter and output
//   half_period : cycles per half wave; 0 holds sq low (rest)
//   en          : run the divider; when low sq is held low
//   sq          : registered square-wave output
module tone_gen
  import sound_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [HALF_W-1:0] half_period,
  input  logic              en,
  output logic              sq
);

  logic [HALF_W-1:0] cnt;

  // Counter wraps at half_period-1 and flips the output, giving a full period
  // of 2*half_period cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sq  <= 1'b0;
    end else if (clear || !en || (half_period == '0)) begin
      cnt <= '0;
      sq  <= 1'b0;
    end else if (cnt == (half_period - HALF_W'(1))) begin
      cnt <= '0;
      sq  <= ~sq;
    end else begin
      cnt <= cnt + HALF_W'(1);
    end
  end

endmodule

// File: rtl/melody_seq.sv
// Note-table melody sequencer driving a square-wave speaker.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : pulse, begins playback at table index 0 (ignored while busy)
//   stop       : pulse, aborts playback (wins over start)
//   loop       : level, sampled at end of table; 1 restarts at index 0
//   sp         : speaker square wave
//   busy       : high whenever not IDLE
//   done       : one-cycle pulse at each end of table
//   note_idx   : table index currently loaded
// Each entry plays for beats*BEAT_TICKS cycles, followed by GAP_TICKS silent
// cycles (GAP_TICKS is expected to be at least 1).
module melody_seq
  import sound_pkg::*;
#(
  parameter int unsigned CLK_HZ     = CLK_HZ_DEF,
  parameter int unsigned BEAT_TICKS = 6_250_000,
  parameter int unsigned GAP_TICKS  = 250_000,
  parameter note_table_t TABLE      = default_table(CLK_HZ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  output logic             sp,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] note_idx
);

  localparam logic [CNT_W-1:0] GAP_LAST =
    (GAP_TICKS == 0) ? '0 : CNT_W'(GAP_TICKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TABLE_LEN - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  dur_last;
  logic [HALF_W-1:0] cur_half;
  logic              armed;

  note_t             entry_c;
  logic              play_last_c;
  logic              gap_last_c;
  logic              table_end_c;
  logic              tone_clear_c;
  logic              tone_en_c;

  assign entry_c     = TABLE[note_idx];
  assign play_last_c = (state == PLAY) && (cnt == dur_last);
  assign gap_last_c  = (state == GAP) && (cnt == GAP_LAST);

  // End of table: an end marker reached in LOAD, or the gap after the last
  // entry has run out.
  assign table_end_c = ((state == LOAD) && (entry_c.half_period == END_MARK)) ||
                       (gap_last_c && (note_idx == IDX_LAST));

  // Tone restarts from a low level on every PLAY entry and goes silent on exit.
  assign tone_clear_c = stop || (state != PLAY) || play_last_c;
  assign tone_en_c    = (state == PLAY);

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      dur_last <= '0;
      cur_half <= '0;
      armed    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      note_idx <= '0;
    end else begin
      // First edge after reset release only arms start acceptance.
      armed <= 1'b1;
      done  <= 1'b0;
      if (stop) begin
        state    <= IDLE;
        cnt      <= '0;
        busy     <= 1'b0;
        note_idx <= '0;
      end else if (table_end_c) begin
        done     <= 1'b1;
        cnt      <= '0;
        note_idx <= '0;
        state    <= loop ? LOAD : IDLE;
        busy     <= loop;
      end else begin
        case (state)
          IDLE: begin
            if (start && armed) begin
              state    <= LOAD;
              busy     <= 1'b1;
              cnt      <= '0;
              note_idx <= '0;
            end
          end
          LOAD: begin
            state    <= PLAY;
            cnt      <= '0;
            cur_half <= entry_c.half_period;
            dur_last <= note_ticks(entry_c.beats, BEAT_TICKS) - CNT_W'(1);
          end
          PLAY: begin
            if (play_last_c) begin
              state <= GAP;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          GAP: begin
            if (gap_last_c) begin
              state    <= LOAD;
              cnt      <= '0;
              note_idx <= note_idx + IDX_W'(1);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  tone_gen u_tone (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (tone_clear_c),
    .half_period (cur_half),
    .en          (tone_en_c),
    .sq          (sp)
  );

endmodule

// File: tb/tb_melody_seq.sv
// Bench for melody_seq: three instances with different note tables share one
// clock and reset. A timeline model expands each table into per-cycle expected
// outputs; a monitor compares them against the DUTs on the falling edge.
module tb_melody_seq;
  import sound_pkg::*;

  localparam int BEAT_T = 10;
  localparam int GAP_T  = 2;
  localparam int NDUT   = 3;
  // Table 0 plays {3,2},{0,1},{2,0} then hits the end marker.
  localparam int LOOP_PERIOD = (2*BEAT_T + GAP_T + 1) + (1*BEAT_T + GAP_T + 1) +
                               (1*BEAT_T + GAP_T + 1) + 1;

  typedef struct packed {
    logic       sp;
    logic       busy;
    logic       done;
    logic [3:0] idx;
  } rec_t;

  localparam rec_t IDLE_REC = '0;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NDUT-1:0] start, stop, loop, sp, busy, done;
  logic [3:0]      idx [NDUT];

  rec_t plan [NDUT][$];
  rec_t sb   [NDUT][$];
  bit   cont [NDUT];
  bit   armed [NDUT];

  int n_checks  = 0;
  int n_fail    = 0;
  int mcyc      = 0;
  int last_done = -1;
  bit measure   = 1'b0;

  always #5 clk = ~clk;

  // 0: short table with rest and end marker; 1: sixteen beats=0 notes;
  // 2: end marker at index 0.
  function automatic note_table_t tbl_of(input int unsigned d);
    note_table_t t;
    for (int unsigned i = 0; i < 16; i++) begin
      t[4'(i)].half_period = (d == 1) ? 16'((i % 5) + 1) : 16'd3;
      t[4'(i)].beats       = (d == 1) ? 3'd0 : 3'd1;
    end
    if (d == 0) begin
      t[0] = '{16'd3, 3'd2};
      t[1] = '{16'd0, 3'd1};
      t[2] = '{16'd2, 3'd0};
      t[3] = '{END_MARK, 3'd0};
    end else if (d == 2) begin
      t[0] = '{END_MARK, 3'd0};
    end
    return t;
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    melody_seq #(
      .CLK_HZ     (25_000_000),
      .BEAT_TICKS (BEAT_T),
      .GAP_TICKS  (GAP_T),
      .TABLE      (tbl_of(g))
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start[g]),
      .stop     (stop[g]),
      .loop     (loop[g]),
      .sp       (sp[g]),
      .busy     (busy[g]),
      .done     (done[g]),
      .note_idx (idx[g])
    );
  end

  // One pass over the table as a list of per-cycle outputs; the cycle after
  // the pass is decided later from the loop level at that edge.
  task automatic build_pass(input int d, input bit done_first);
    note_table_t t;
    note_t       e;
    rec_t        r;
    int          half, dur;
    t = tbl_of(d);
    for (int i = 0; i < 16; i++) begin
      e = t[4'(i)];
      r = '{sp: 1'b0, busy: 1'b1, done: done_first && (i == 0), idx: 4'(i)};
      plan[d].push_back(r);
      if (e.half_period == END_MARK) break;
      half   = int'(e.half_period);
      dur    = ((e.beats == 3'd0) ? 1 : int'(e.beats)) * BEAT_T;
      r.done = 1'b0;
      for (int k = 0; k < dur; k++) begin
        r.sp = (half == 0) ? 1'b0 : 1'((k / half) % 2);
        plan[d].push_back(r);
      end
      r.sp = 1'b0;
      repeat (GAP_T) plan[d].push_back(r);
    end
    cont[d] = 1'b1;
  endtask

  // Expected outputs for the cycle following the edge that sampled the inputs.
  task automatic model_advance(input int d, input logic s_start, input logic s_stop);
    rec_t r;
    r = IDLE_REC;
    if (!rst_n) begin
      plan[d].delete();
      cont[d]  = 1'b0;
      armed[d] = 1'b0;
    end else begin
      if (s_stop) begin
        plan[d].delete();
        cont[d] = 1'b0;
      end else if (plan[d].size() != 0) begin
        r = plan[d].pop_front();
      end else if (cont[d]) begin
        cont[d] = 1'b0;
        if (loop[d]) begin
          build_pass(d, 1'b1);
          r = plan[d].pop_front();
        end else begin
          r.done = 1'b1;
        end
      end else if (s_start && armed[d]) begin
        build_pass(d, 1'b0);
        r = plan[d].pop_front();
      end
      armed[d] = 1'b1;
    end
    sb[d].push_back(r);
  endtask

  task automatic step(input logic [NDUT-1:0] s_start, input logic [NDUT-1:0] s_stop);
    start = s_start;
    stop  = s_stop;
    @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) model_advance(d, s_start[d], s_stop[d]);
    start = '0;
    stop  = '0;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    rec_t e;
    mcyc++;
    for (int d = 0; d < NDUT; d++) begin
      if (sb[d].size() != 0) begin
        e = sb[d].pop_front();
        n_checks++;
        if (sp[d] !== e.sp || busy[d] !== e.busy || done[d] !== e.done || idx[d] !== e.idx) begin
          n_fail++;
          $display("FAIL dut%0d cycle %0d: got sp=%b busy=%b done=%b idx=%0d, want sp=%b busy=%b done=%b idx=%0d",
                   d, mcyc, sp[d], busy[d], done[d], idx[d], e.sp, e.busy, e.done, e.idx);
        end
      end
    end
    if (measure && done[0] === 1'b1) begin
      if (last_done >= 0) begin
        n_checks++;
        if (mcyc - last_done != LOOP_PERIOD) begin
          n_fail++;
          $display("FAIL loop_period: got %0d cycles, want %0d", mcyc - last_done, LOOP_PERIOD);
        end
      end
      last_done = mcyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    logic [NDUT-1:0] rs, rp;
    rst_n = 1'b0;
    start = '0;
    stop  = '0;
    loop  = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      n_checks++;
      if ({sp[d], busy[d], done[d], idx[d]} !== 7'd0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: got %b, want 0000000", d, {sp[d], busy[d], done[d], idx[d]});
      end
    end
    #2 rst_n = 1'b1;

    // Start on the first edge after release is too early; the next one counts.
    step('1, '0);
    step('0, '0);
    step('1, '0);
    for (int n = 0; n < 240; n++) begin
      if (n == 20) step(3'b001, '0);       // dut0 busy: ignored
      else if (n == 5) step(3'b100, '0);   // dut2 already idle: replays
      else step('0, '0);
    end

    // Looping: dut0 period between done pulses; dut2 spins on its end marker.
    loop    = 3'b101;
    measure = 1'b1;
    step(3'b101, '0);
    for (int n = 0; n < 170; n++) begin
      if (n == 10) step('0, 3'b100);
      else step('0, '0);
    end
    measure = 1'b0;
    loop    = '0;
    repeat (60) step('0, '0);

    // Stop during note 1 of dut1, with start in the same cycle; idle dut0 too.
    step(3'b010, '0);
    repeat (18) step('0, '0);
    step(3'b011, 3'b011);
    repeat (10) step('0, '0);

    // Asynchronous reset while dut0 is driving sp high.
    step(3'b001, '0);
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      step('0, '0);
      if (sb[0][$].sp == 1'b1) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL reach_sp_high: got found=0, want 1");
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (sp[0] !== 1'b0 || busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got sp=%b busy=%b, want sp=0 busy=0", sp[0], busy[0]);
    end
    for (int d = 0; d < NDUT; d++) begin
      sb[d].delete();
      plan[d].delete();
      cont[d]  = 1'b0;
      armed[d] = 1'b0;
    end
    repeat (3) step('1, '0);
    #2 rst_n = 1'b1;
    step(3'b001, '0);
    step('0, '0);
    step(3'b001, '0);
    repeat (60) step('0, '0);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      for (int d = 0; d < NDUT; d++) begin
        rs[d] = ($urandom_range(0, 19) == 0);
        rp[d] = ($urandom_range(0, 79) == 0);
        if ($urandom_range(0, 99) == 0) loop[d] = ~loop[d];
      end
      step(rs, rp);
    end
    loop = '0;
    repeat (300) step('0, '0);

    @(negedge clk);
    #1;
    n_checks++;
    if (sb[0].size() + sb[1].size() + sb[2].size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb[0].size() + sb[1].size() + sb[2].size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
